startframe_if_w_deconvert: RTL and testbench
============================================

# startframe_if_w_deconvert

Converts a startframe/endframe-framed stream into a last-terminated stream with padbytes, and enforces framing on the way. Orphan beats outside a frame are dropped. A frame that is missing its endframe is truncated by forcing `last` onto its final held beat. A one-beat lookahead hold register lets the block decide `last` before releasing a beat. It sits at MAC/host-facing boundaries that deliver start/end-delimited frames into the data path's `val/data/last/padbytes/rdy` interfaces.

## Interface
- `DATA_W`, default 0 (must be overridden, multiple of 8): beat width in bits.
- `PADBYTES_W`, default `BSG_SAFE_CLOG2(DATA_W/8)`: padbytes field width.
- `clk`  in  1  clock.
- `rst`  in  1  reset. Asynchronous, active-high.
- `src_deconvert_val`  in  1  input beat valid.
- `src_deconvert_startframe`  in  1  beat is first of frame.
- `src_deconvert_endframe`  in  1  beat is last of frame.
- `src_deconvert_data`  in  DATA_W  beat data.
- `src_deconvert_padbytes`  in  PADBYTES_W  invalid bytes in beat; meaningful on endframe only.
- `deconvert_src_rdy`  out  1  input accepted when high with `src_deconvert_val`.
- `deconvert_dst_data_val`  out  1  output beat valid.
- `deconvert_dst_data`  out  DATA_W  output data.
- `deconvert_dst_data_last`  out  1  output beat ends frame.
- `deconvert_dst_data_padbytes`  out  PADBYTES_W  padbytes. Passed through from `last` beats; 0 on truncated beats.
- `dst_deconvert_data_rdy`  in  1  downstream ready.

## Operation
- The state machine has two states: IDLE (outside a frame) and IN_FRAME. Holding storage is one entry: `hold_val`, `hold_data`, `hold_pad`, `hold_last`.
- IDLE, beat with startframe: loaded into hold. If endframe is also set, `hold_last=1` and the state stays IDLE. Otherwise the state goes to IN_FRAME.
- IDLE, beat without startframe (orphan): accepted and discarded (`deconvert_src_rdy=1` regardless of downstream). The state stays IDLE.
- IN_FRAME, beat without startframe: replaces hold when the hold beat is emitted. If endframe is set, `hold_last=1` and the state goes to IDLE.
- IN_FRAME, beat with startframe (missing endframe): the currently held beat is emitted with `last=1` and padbytes 0 (truncation). The new beat is loaded as the start of a new frame, with the same endframe rule as IDLE.
- Output valid is `hold_val & (hold_last | src_deconvert_val)`.
  - A non-last beat is released only when its successor is presented.
  - Output `last` is `hold_last | (src_deconvert_val & src_deconvert_startframe)` for a held non-last beat.
- Input ready:
  - `~hold_val`, or
  - output handshake this cycle, or
  - orphan in IDLE.
- A non-orphan input is accepted only in the same cycle the held beat leaves or when hold is empty. There is no bypass path.
- Beats carrying startframe and endframe together, including a single-beat frame, are legal.

## Timing
- Reset (async assert, sync-safe deassert) sets state to IDLE, `hold_val=0`, and counters to 0.
  - `deconvert_dst_data_val=0` and `deconvert_src_rdy=0` while `rst` is high.
  - Data/padbytes outputs are don't-care while valid is low.
- Latency:
  - A `last` beat appears at the output the cycle after acceptance.
  - A non-last beat appears the cycle after acceptance, but only once its successor is valid on the input.
- Full throughput of one beat per cycle is sustained while both sides are ready and the input is continuous.
- Valid and payload hold stable while `deconvert_dst_data_val & ~dst_deconvert_data_rdy`. The exception is the case where input val drops under a held non-last beat, which lowers output valid.
- Reset mid-frame discards the held beat. No `last` is emitted.

## Configuration
- The macro `STARTFRAME_DECONVERT_ERR_CNT_EN` controls error counting.
- Defined: two extra outputs are added.
  - `deconvert_orphan_cnt`, 16 bits: counts each dropped orphan beat.
  - `deconvert_trunc_cnt`, 16 bits: counts each truncation.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: the ports and counters are absent. Drop and truncate behaviour is unchanged.

## Structure
- Shared package `startframe_deconvert_pkg` contains the `deconvert_state_e` enum (IDLE, IN_FRAME) and the counter width constant `DECONVERT_CNT_W=16`.
- Sub-module `startframe_deconvert_hold` is the one-entry hold register, with load/unload strobes and a `force_last` input. The FSM and counters live in the top module.

## Test plan
- 3-beat frame (SF, mid, EF with padbytes=5), dst always ready: out beats 1,2,3; `last` only on beat 3 with padbytes=5; beat 3 out one cycle after accept.
- Single beat with SF+EF=1, padbytes=2: one output with `last=1`, padbytes=2; state stays IDLE.
- Two non-SF beats in IDLE, then an SF+EF beat: both orphans accepted with no output; the SF+EF beat is the only output; orphan_cnt=2 when the macro is defined.
- SF, mid, then SF without EF, then EF: the mid beat is out with `last=1`, padbytes=0; the new frame follows normally; trunc_cnt=1.
- 4-beat frame with dst_rdy toggling 1,0,0,1 each cycle: no beat is lost or duplicated; output is stable while stalled.
- Assert `rst` asynchronously while hold holds a mid-frame beat: valid drops immediately; a following SF frame outputs cleanly.

Source files
------------

// File: rtl/startframe_deconvert_pkg.sv
// Shared definitions for the startframe/endframe to last/padbytes converter.
//   deconvert_state_e : framing state (IDLE outside a frame, IN_FRAME inside)
//   DECONVERT_CNT_W   : width of the optional error counters
//   safe_clog2        : clog2 that never returns 0, used for the padbytes width
package startframe_deconvert_pkg;

    localparam int unsigned DECONVERT_CNT_W = 16;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } deconvert_state_e;

    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/startframe_if_w_deconvert_if.sv
// Bus bundle for startframe_if_w_deconvert.
//   Source side : src_deconvert_{val,startframe,endframe,data,padbytes}, deconvert_src_rdy
//   Dest side   : deconvert_dst_data{_val,,_last,_padbytes}, dst_deconvert_data_rdy
// Modports:
//   master : the environment (drives the source beats and downstream ready)
//   slave  : the converter block
interface startframe_if_w_deconvert_if
    import startframe_deconvert_pkg::*;
#(
    parameter int unsigned DATA_W     = 0,
    parameter int unsigned PADBYTES_W = safe_clog2(DATA_W / 8)
);

    logic                  src_deconvert_val;
    logic                  src_deconvert_startframe;
    logic                  src_deconvert_endframe;
    logic [DATA_W-1:0]     src_deconvert_data;
    logic [PADBYTES_W-1:0] src_deconvert_padbytes;
    logic                  deconvert_src_rdy;

    logic                  deconvert_dst_data_val;
    logic [DATA_W-1:0]     deconvert_dst_data;
    logic                  deconvert_dst_data_last;
    logic [PADBYTES_W-1:0] deconvert_dst_data_padbytes;
    logic                  dst_deconvert_data_rdy;

    modport master (
        output src_deconvert_val,
        output src_deconvert_startframe,
        output src_deconvert_endframe,
        output src_deconvert_data,
        output src_deconvert_padbytes,
        input  deconvert_src_rdy,
        input  deconvert_dst_data_val,
        input  deconvert_dst_data,
        input  deconvert_dst_data_last,
        input  deconvert_dst_data_padbytes,
        output dst_deconvert_data_rdy
    );

    modport slave (
        input  src_deconvert_val,
        input  src_deconvert_startframe,
        input  src_deconvert_endframe,
        input  src_deconvert_data,
        input  src_deconvert_padbytes,
        output deconvert_src_rdy,
        output deconvert_dst_data_val,
        output deconvert_dst_data,
        output deconvert_dst_data_last,
        output deconvert_dst_data_padbytes,
        input  dst_deconvert_data_rdy
    );

endinterface

// File: rtl/startframe_deconvert_hold.sv
// One-entry lookahead hold register for the deconverter.
//   clk, rst       : clock, async active-high reset (empties the entry)
//   load_i         : capture data_i/pad_i/last_i (wins over unload_i)
//   unload_i       : entry leaves this cycle
//   force_last_i   : mark the held beat as last on the way out (truncation)
//   val_o/data_o   : entry occupied / held data
//   pad_o          : held padbytes on last beats, 0 otherwise
//   last_o         : held last flag OR force_last_i
//   hold_last_o    : raw stored last flag
module startframe_deconvert_hold #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PADBYTES_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  unload_i,
    input  logic                  force_last_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [PADBYTES_W-1:0] pad_i,
    input  logic                  last_i,
    output logic                  val_o,
    output logic [DATA_W-1:0]     data_o,
    output logic [PADBYTES_W-1:0] pad_o,
    output logic                  last_o,
    output logic                  hold_last_o
);

    logic                  val_q;
    logic [DATA_W-1:0]     data_q;
    logic [PADBYTES_W-1:0] pad_q;
    logic                  last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q  <= 1'b0;
            data_q <= '0;
            pad_q  <= '0;
            last_q <= 1'b0;
        end else if (load_i) begin
            val_q  <= 1'b1;
            data_q <= data_i;
            pad_q  <= pad_i;
            last_q <= last_i;
        end else if (unload_i) begin
            val_q  <= 1'b0;
        end
    end

    assign val_o       = val_q;
    assign data_o      = data_q;
    // Padbytes only carry meaning on a genuine endframe beat; truncated beats report 0.
    assign pad_o       = last_q ? pad_q : '0;
    assign last_o      = last_q | force_last_i;
    assign hold_last_o = last_q;

endmodule

// File: rtl/startframe_if_w_deconvert.sv
// Converts a startframe/endframe framed stream into a last/padbytes terminated stream.
// Orphan beats outside a frame are dropped; a frame missing its endframe is truncated by
// forcing last onto its held beat when the next startframe arrives.
//   clk, rst : clock, async active-high reset
//   bus      : startframe_if_w_deconvert_if.slave (source beats in, last-framed beats out)
// Optional feature macro STARTFRAME_DECONVERT_ERR_CNT_EN adds saturating 16-bit
// deconvert_orphan_cnt and deconvert_trunc_cnt outputs.
module startframe_if_w_deconvert
    import startframe_deconvert_pkg::*;
#(
    parameter int unsigned DATA_W     = 0,
    parameter int unsigned PADBYTES_W = safe_clog2(DATA_W / 8)
) (
    input  logic                       clk,
    input  logic                       rst,
    startframe_if_w_deconvert_if.slave bus
`ifdef STARTFRAME_DECONVERT_ERR_CNT_EN
    ,
    output logic [DECONVERT_CNT_W-1:0] deconvert_orphan_cnt,
    output logic [DECONVERT_CNT_W-1:0] deconvert_trunc_cnt
`endif
);

    deconvert_state_e state_q, state_d;

    logic in_val, in_sf, in_ef;
    logic hold_val, hold_last;
    logic out_val, out_fire;
    logic orphan, src_rdy, accept, load, trunc;

    assign in_val = bus.src_deconvert_val;
    assign in_sf  = bus.src_deconvert_startframe;
    assign in_ef  = bus.src_deconvert_endframe;

    // Orphans are swallowed whatever the downstream is doing.
    assign orphan   = in_val & ~in_sf & (state_q == IDLE);
    // A non-last held beat is only released once its successor is on the input.
    assign out_val  = hold_val & (hold_last | in_val);
    assign out_fire = out_val & bus.dst_deconvert_data_rdy;
    assign src_rdy  = ~rst & (~hold_val | out_fire | orphan);
    assign accept   = in_val & src_rdy;
    assign load     = accept & ~orphan;
    // Held beat is non-last only inside a frame, so a startframe here means truncation.
    assign trunc    = out_fire & ~hold_last & in_val & in_sf;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = in_ef ? IDLE : IN_FRAME;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    startframe_deconvert_hold #(
        .DATA_W     (DATA_W),
        .PADBYTES_W (PADBYTES_W)
    ) u_hold (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .unload_i     (out_fire),
        .force_last_i (in_val & in_sf),
        .data_i       (bus.src_deconvert_data),
        .pad_i        (bus.src_deconvert_padbytes),
        .last_i       (in_ef),
        .val_o        (hold_val),
        .data_o       (bus.deconvert_dst_data),
        .pad_o        (bus.deconvert_dst_data_padbytes),
        .last_o       (bus.deconvert_dst_data_last),
        .hold_last_o  (hold_last)
    );

    assign bus.deconvert_dst_data_val = out_val;
    assign bus.deconvert_src_rdy      = src_rdy;

`ifdef STARTFRAME_DECONVERT_ERR_CNT_EN
    logic [DECONVERT_CNT_W-1:0] orphan_cnt_q, orphan_cnt_d;
    logic [DECONVERT_CNT_W-1:0] trunc_cnt_q, trunc_cnt_d;

    always_comb begin
        orphan_cnt_d = orphan_cnt_q;
        trunc_cnt_d  = trunc_cnt_q;
        if (accept && orphan && (orphan_cnt_q != '1)) begin
            orphan_cnt_d = orphan_cnt_q + 1'b1;
        end
        if (trunc && (trunc_cnt_q != '1)) begin
            trunc_cnt_d = trunc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orphan_cnt_q <= '0;
            trunc_cnt_q  <= '0;
        end else begin
            orphan_cnt_q <= orphan_cnt_d;
            trunc_cnt_q  <= trunc_cnt_d;
        end
    end

    assign deconvert_orphan_cnt = orphan_cnt_q;
    assign deconvert_trunc_cnt  = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_startframe_if_w_deconvert.sv
// Randomised, scoreboard-checked bench for startframe_if_w_deconvert.
module tb_startframe_if_w_deconvert;

    localparam int unsigned DW = 64;
    localparam int unsigned PW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    startframe_if_w_deconvert_if #(.DATA_W(DW), .PADBYTES_W(PW)) bus ();

`ifdef STARTFRAME_DECONVERT_ERR_CNT_EN
    logic [15:0] orphan_cnt, trunc_cnt;
`endif

    startframe_if_w_deconvert #(
        .DATA_W     (DW),
        .PADBYTES_W (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef STARTFRAME_DECONVERT_ERR_CNT_EN
        ,
        .deconvert_orphan_cnt (orphan_cnt),
        .deconvert_trunc_cnt  (trunc_cnt)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [PW-1:0] pad;
        bit            chk_lat;
        int            acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dst_mode = 0;

    // Frame-level reference model
    bit            m_in_frame = 0;
    logic [DW-1:0] m_pend;
    int            m_orphans = 0;
    int            m_truncs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void push(input logic [DW-1:0] d, input logic l, input logic [PW-1:0] p,
                                 input bit lat);
        exp_t e;
        e.data = d; e.last = l; e.pad = p; e.chk_lat = lat; e.acc_cyc = cyc;
        exp_q.push_back(e);
    endfunction

    function automatic void model_accept(input bit sf, input bit ef, input logic [DW-1:0] d,
                                         input logic [PW-1:0] p);
        if (!sf && !m_in_frame) begin
            m_orphans++;
        end else begin
            if (m_in_frame) begin
                push(m_pend, sf, '0, 0);
                if (sf) m_truncs++;
            end
            if (ef) begin
                push(d, 1'b1, p, 1);
                m_in_frame = 0;
            end else begin
                m_pend = d;
                m_in_frame = 1;
            end
        end
    endfunction

    function automatic void model_reset();
        m_in_frame = 0;
        m_orphans = 0;
        m_truncs = 0;
        exp_q.delete();
    endfunction

    // Monitor: model update on input handshake, then compare on output handshake.
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [PW-1:0] prev_pad;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (bus.src_deconvert_val && bus.deconvert_src_rdy)
                model_accept(bus.src_deconvert_startframe, bus.src_deconvert_endframe,
                             bus.src_deconvert_data, bus.src_deconvert_padbytes);
            if (prev_stall && !(!prev_last && !bus.src_deconvert_val)) begin
                chk("stall_val", bus.deconvert_dst_data_val, 1'b1);
                chk("stall_data", bus.deconvert_dst_data, prev_data);
                chk("stall_last", bus.deconvert_dst_data_last, prev_last);
                if (prev_last) chk("stall_pad", bus.deconvert_dst_data_padbytes, prev_pad);
            end
            if (bus.deconvert_dst_data_val && bus.dst_deconvert_data_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", bus.deconvert_dst_data, 64'hx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", bus.deconvert_dst_data, e.data);
                    chk("out_last", bus.deconvert_dst_data_last, e.last);
                    if (e.last) chk("out_pad", bus.deconvert_dst_data_padbytes, e.pad);
                    if (e.chk_lat && dst_mode == 0) chk("last_latency", cyc, e.acc_cyc + 1);
                end
            end
            prev_stall = bus.deconvert_dst_data_val & ~bus.dst_deconvert_data_rdy;
            prev_data  = bus.deconvert_dst_data;
            prev_last  = bus.deconvert_dst_data_last;
            prev_pad   = bus.deconvert_dst_data_padbytes;
        end
    end

    // Downstream ready driver: 0 always, 1 random, 2 pattern 1,0,0,1, 3 never.
    initial begin
        bit [3:0] pat;
        int pidx;
        pat = 4'b1001;
        pidx = 0;
        bus.dst_deconvert_data_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (dst_mode)
                0: bus.dst_deconvert_data_rdy = 1'b1;
                1: bus.dst_deconvert_data_rdy = 1'($urandom_range(0, 1));
                2: begin
                    bus.dst_deconvert_data_rdy = pat[pidx];
                    pidx = (pidx + 1) % 4;
                end
                default: bus.dst_deconvert_data_rdy = 1'b0;
            endcase
        end
    end

    task automatic send(input bit sf, input bit ef, input logic [DW-1:0] d,
                        input logic [PW-1:0] p);
        bus.src_deconvert_val        = 1'b1;
        bus.src_deconvert_startframe = sf;
        bus.src_deconvert_endframe   = ef;
        bus.src_deconvert_data       = d;
        bus.src_deconvert_padbytes   = p;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (bus.deconvert_src_rdy) break;
            if (i >= 200) begin
                chk("send_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.src_deconvert_val = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic chk_cnts(input string tag);
`ifdef STARTFRAME_DECONVERT_ERR_CNT_EN
        chk({tag, "_orphan_cnt"}, orphan_cnt, m_orphans);
        chk({tag, "_trunc_cnt"}, trunc_cnt, m_truncs);
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.src_deconvert_val        = 1'b0;
        bus.src_deconvert_startframe = 1'b0;
        bus.src_deconvert_endframe   = 1'b0;
        bus.src_deconvert_data       = '0;
        bus.src_deconvert_padbytes   = '0;
        #1;
        chk("reset_out_val", bus.deconvert_dst_data_val, 1'b0);
        chk("reset_src_rdy", bus.deconvert_src_rdy, 1'b0);
        chk_cnts("reset");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("post_reset_src_rdy", bus.deconvert_src_rdy, 1'b1);
        idle(1);

        // 3-beat frame, dst always ready
        dst_mode = 0;
        send(1, 0, 64'h1111, 0);
        send(0, 0, 64'h2222, 0);
        send(0, 1, 64'h3333, 5);
        idle(2);
        drain();

        // single-beat frame then orphans then SF+EF
        send(1, 1, 64'h4444, 2);
        idle(1);
        send(0, 0, 64'h5555, 1);
        send(0, 1, 64'h6666, 1);
        send(1, 1, 64'h7777, 3);
        idle(2);
        drain();
        chk_cnts("orphan");

        // truncation: SF, mid, SF, EF
        send(1, 0, 64'h8888, 0);
        send(0, 0, 64'h9999, 0);
        send(1, 0, 64'haaaa, 0);
        send(0, 1, 64'hbbbb, 3);
        idle(2);
        drain();
        chk_cnts("trunc");

        // 4-beat frame under 1,0,0,1 ready pattern
        dst_mode = 2;
        send(1, 0, 64'hc001, 0);
        send(0, 0, 64'hc002, 0);
        send(0, 0, 64'hc003, 0);
        send(0, 1, 64'hc004, 6);
        drain();

        // async reset with a mid-frame beat held and output valid
        dst_mode = 3;
        idle(2);
        send(1, 0, 64'hd001, 0);
        bus.src_deconvert_val        = 1'b1;
        bus.src_deconvert_startframe = 1'b0;
        bus.src_deconvert_endframe   = 1'b0;
        bus.src_deconvert_data       = 64'hd002;
        idle(2);
        chk("pre_reset_out_val", bus.deconvert_dst_data_val, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_reset_out_val", bus.deconvert_dst_data_val, 1'b0);
        chk("async_reset_src_rdy", bus.deconvert_src_rdy, 1'b0);
        bus.src_deconvert_val = 1'b0;
        dst_mode = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(1);
        chk_cnts("after_reset");
        send(1, 0, 64'he001, 0);
        send(0, 1, 64'he002, 1);
        idle(2);
        drain();

        // randomised traffic
        dst_mode = 1;
        for (int n = 0; n < 300; n++) begin
            bit sf, ef;
            sf = ($urandom_range(0, 3) == 0);
            ef = ($urandom_range(0, 9) < 3);
            send(sf, ef, {$urandom, $urandom}, PW'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        send(1, 1, 64'hf00d, 4);
        drain();
        chk_cnts("random");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
